regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning:
- BW_DATA, 32, register width in bits
- BW_ADDR, 5, address width; depth = 2**BW_ADDR
- N_RD, 2, number of read ports, legal range 1..4
- ZERO_REG, 1, when 1, entry 0 is hardwired to zero
- BYPASS, 1, when 1, same-cycle write data is forwarded to reads
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning (clock and reset first):
- i_clk, in, 1, single clock; all state updates on its rising edge
- i_rst, in, 1, synchronous reset, active-high
- i_rf_rd_addr, in, N_RD*BW_ADDR, packed read addresses; port k uses bits [k*BW_ADDR +: BW_ADDR]
- o_rf_rd_data, out, N_RD*BW_DATA, packed asynchronous read data; port k uses bits [k*BW_DATA +: BW_DATA]
- i_rf_wr_en0, in, 1, write port 0 enable
- i_rf_wr_addr0, in, BW_ADDR, write port 0 address
- i_rf_wr_data0, in, BW_DATA, write port 0 data
- i_rf_wr_en1, in, 1, write port 1 enable
- i_rf_wr_addr1, in, BW_ADDR, write port 1 address
- i_rf_wr_data1, in, BW_DATA, write port 1 data
- i_rf_clr, in, 1, request a full-array clear sweep
- o_rf_ready, out, 1, high when the array is usable
- o_rf_wr_conflict, out, 1, one-cycle pulse flagging a same-address dual write in the previous cycle
REQ-003 The block SHALL use one clock (i_clk) and a synchronous, active-high reset (i_rst).

Function
REQ-004 Control SHALL be a two-state FSM, CLEAR and READY, with a clear counter clr_cnt of BW_ADDR bits.
REQ-005 In CLEAR, entry clr_cnt SHALL be written with 0 each cycle and clr_cnt SHALL increment.
- Transition: after entry 2**BW_ADDR-1 is written, go to READY on the same edge; clr_cnt wraps to 0.
REQ-006 In CLEAR, both write ports SHALL be ignored, i_rf_clr SHALL be ignored, o_rf_ready SHALL be 0, and every o_rf_rd_data lane SHALL read 0.
REQ-007 In READY, o_rf_ready SHALL be 1.
- i_rf_clr=1 SHALL move the FSM to CLEAR with clr_cnt=0; the write ports are not honoured on that edge.
REQ-008 In READY, a write port with en=1 SHALL update entry addr with its data on the rising edge; write latency is 1 cycle.
REQ-009 If both ports write the same address in one cycle, port 1 data SHALL win.
- o_rf_wr_conflict SHALL be 1 for exactly the following cycle; otherwise 0.
REQ-010 If both ports write different addresses in one cycle, both entries SHALL be updated.
REQ-011 Reads SHALL be combinational: each lane returns the array entry at its address in the same cycle.
REQ-012 With BYPASS=1 in READY, a read address matching an enabled write address SHALL return that write data (port 1 over port 0).
- With BYPASS=0, the read SHALL return the pre-write array value.
REQ-013 With ZERO_REG=1, writes to address 0 SHALL be dropped; reads of address 0 SHALL return 0, including under bypass.
- A port-0/port-1 collision at address 0 SHALL NOT raise o_rf_wr_conflict.
REQ-014 Entries with no enabled write SHALL hold their value.
REQ-015 Read lanes SHALL be independent; any number of lanes may read the same address.

Reset
REQ-016 While i_rst=1 at a rising edge:
- FSM goes to CLEAR, clr_cnt=0, o_rf_ready=0, o_rf_wr_conflict=0.
- Array contents are not reset directly; they are zeroed by the subsequent sweep.
REQ-017 Reset asserted mid-sweep SHALL restart the sweep at entry 0.
- Reset has priority over i_rf_clr and all writes.
REQ-018 After i_rst deasserts, o_rf_ready SHALL rise exactly 2**BW_ADDR cycles later (32 for defaults).

Verification
REQ-019 Reset release sweep: release i_rst, count edges -> o_rf_ready=0 for 32 cycles, then 1; all 32 entries read 0.
REQ-020 Write then read: write0 addr 3 = 0xDEADBEEF -> next cycle, lane 0 addr 3 = 0xDEADBEEF; same-cycle read = 0xDEADBEEF with BYPASS=1, 0 with BYPASS=0.
REQ-021 Dual-write conflict: write0 addr 7 = 0x11, write1 addr 7 = 0x22 -> entry 7 = 0x22; o_rf_wr_conflict=1 for one cycle.
- Dual write to addr 4 = 0xA and addr 5 = 0xB -> both stored; no conflict.
REQ-022 Zero register: write addr 0 = 0xFFFFFFFF with ZERO_REG=1 -> lane reads of addr 0 = 0, same-cycle bypass read = 0.
REQ-023 Clear mid-operation: fill entries 1..31, pulse i_rf_clr, attempt write during sweep -> o_rf_ready low 32 cycles, write ignored, all entries 0 afterwards.
REQ-024 Reset mid-sweep: assert i_rst at sweep cycle 10 for 1 cycle -> o_rf_ready rises 32 cycles after deassert.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read, dual-write register file with a clear sweep.
//
// After reset or a clear request, a sweep writes zero to every entry, one per
// cycle. The array is usable only once the sweep finishes.
//
// Ports:
//   i_clk            clock; all state updates on its rising edge
//   i_rst            synchronous reset, active-high
//   i_rf_rd_addr     packed read addresses, lane k at [k*BW_ADDR +: BW_ADDR]
//   o_rf_rd_data     packed combinational read data, lane k at [k*BW_DATA +: BW_DATA]
//   i_rf_wr_en0/1    write enables for write ports 0 and 1
//   i_rf_wr_addr0/1  write addresses
//   i_rf_wr_data0/1  write data
//   i_rf_clr         starts a full-array clear sweep (honoured only when ready)
//   o_rf_ready       high when the array is usable
//   o_rf_wr_conflict one-cycle pulse after a same-address dual write
module regfile_mp #(
  parameter int unsigned BW_DATA  = 32,
  parameter int unsigned BW_ADDR  = 5,
  parameter int unsigned N_RD     = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_RD*BW_ADDR-1:0] i_rf_rd_addr,
  output logic [N_RD*BW_DATA-1:0] o_rf_rd_data,
  input  logic                    i_rf_wr_en0,
  input  logic [BW_ADDR-1:0]      i_rf_wr_addr0,
  input  logic [BW_DATA-1:0]      i_rf_wr_data0,
  input  logic                    i_rf_wr_en1,
  input  logic [BW_ADDR-1:0]      i_rf_wr_addr1,
  input  logic [BW_DATA-1:0]      i_rf_wr_data1,
  input  logic                    i_rf_clr,
  output logic                    o_rf_ready,
  output logic                    o_rf_wr_conflict
);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e             state_q;
  logic [BW_ADDR-1:0] clr_cnt_q;
  logic               conflict_q;
  logic [BW_DATA-1:0] mem_q [2**BW_ADDR];

  logic wr_ok;
  logic we0;
  logic we1;
  logic conflict_d;

  // Writes are honoured only in READY and not on the edge that starts a clear.
  // Writes to entry 0 are dropped entirely when it is hardwired to zero, which
  // also keeps an address-0 collision from flagging a conflict.
  assign wr_ok      = (state_q == StReady) && !i_rf_clr;
  assign we0        = wr_ok && i_rf_wr_en0 && !(ZERO_REG && (i_rf_wr_addr0 == '0));
  assign we1        = wr_ok && i_rf_wr_en1 && !(ZERO_REG && (i_rf_wr_addr1 == '0));
  assign conflict_d = we0 && we1 && (i_rf_wr_addr0 == i_rf_wr_addr1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StClear;
      clr_cnt_q  <= '0;
      conflict_q <= 1'b0;
    end else begin
      conflict_q <= conflict_d;
      case (state_q)
        StClear: begin
          // Counter wraps to 0 on the same edge the last entry is cleared.
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == '1) begin
            state_q <= StReady;
          end
        end
        StReady: begin
          if (i_rf_clr) begin
            state_q   <= StClear;
            clr_cnt_q <= '0;
          end
        end
        default: begin
          state_q   <= StClear;
          clr_cnt_q <= '0;
        end
      endcase
    end
  end

  // Array storage has no reset; the sweep zeroes it.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state_q == StClear) begin
        mem_q[clr_cnt_q] <= '0;
      end else begin
        if (we0) begin
          mem_q[i_rf_wr_addr0] <= i_rf_wr_data0;
        end
        // Port 1 is assigned last so it wins a same-address collision.
        if (we1) begin
          mem_q[i_rf_wr_addr1] <= i_rf_wr_data1;
        end
      end
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [BW_ADDR-1:0] ra;
    logic [BW_DATA-1:0] rd;

    assign ra = i_rf_rd_addr[k*BW_ADDR +: BW_ADDR];

    always_comb begin
      rd = mem_q[ra];
      if (BYPASS && we0 && (i_rf_wr_addr0 == ra)) begin
        rd = i_rf_wr_data0;
      end
      if (BYPASS && we1 && (i_rf_wr_addr1 == ra)) begin
        rd = i_rf_wr_data1;
      end
      if ((state_q != StReady) || (ZERO_REG && (ra == '0))) begin
        rd = '0;
      end
    end

    assign o_rf_rd_data[k*BW_DATA +: BW_DATA] = rd;
  end

  assign o_rf_ready       = (state_q == StReady);
  assign o_rf_wr_conflict = conflict_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp. Two instances share all inputs: one with
// write bypass, one without. A behavioural model tracks readiness, the sweep
// position and the array contents.
module tb_regfile_mp;

  localparam int unsigned BW_DATA = 32;
  localparam int unsigned BW_ADDR = 5;
  localparam int unsigned N_RD    = 2;
  localparam int unsigned DEPTH   = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [N_RD*BW_ADDR-1:0] rd_addr;
  logic [N_RD*BW_DATA-1:0] rd_data_b;
  logic [N_RD*BW_DATA-1:0] rd_data_n;
  logic                    wr_en0;
  logic [BW_ADDR-1:0]      wr_addr0;
  logic [BW_DATA-1:0]      wr_data0;
  logic                    wr_en1;
  logic [BW_ADDR-1:0]      wr_addr1;
  logic [BW_DATA-1:0]      wr_data1;
  logic                    clr;
  logic                    ready_b, ready_n;
  logic                    conf_b, conf_n;

  regfile_mp #(.BYPASS(1'b1)) dut_b (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rf_rd_addr     (rd_addr),
    .o_rf_rd_data     (rd_data_b),
    .i_rf_wr_en0      (wr_en0),
    .i_rf_wr_addr0    (wr_addr0),
    .i_rf_wr_data0    (wr_data0),
    .i_rf_wr_en1      (wr_en1),
    .i_rf_wr_addr1    (wr_addr1),
    .i_rf_wr_data1    (wr_data1),
    .i_rf_clr         (clr),
    .o_rf_ready       (ready_b),
    .o_rf_wr_conflict (conf_b)
  );

  regfile_mp #(.BYPASS(1'b0)) dut_n (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_rf_rd_addr     (rd_addr),
    .o_rf_rd_data     (rd_data_n),
    .i_rf_wr_en0      (wr_en0),
    .i_rf_wr_addr0    (wr_addr0),
    .i_rf_wr_data0    (wr_data0),
    .i_rf_wr_en1      (wr_en1),
    .i_rf_wr_addr1    (wr_addr1),
    .i_rf_wr_data1    (wr_data1),
    .i_rf_clr         (clr),
    .o_rf_ready       (ready_n),
    .o_rf_wr_conflict (conf_n)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model
  bit          m_ready = 1'b0;
  int          m_sweep = 0;
  bit          m_conf  = 1'b0;
  logic [31:0] m_mem [DEPTH];

  function automatic logic [31:0] exp_rd(input bit byp, input logic [BW_ADDR-1:0] a);
    if (!m_ready || a == 0) return 32'h0;
    if (byp && !clr) begin
      if (wr_en1 && wr_addr1 == a) return wr_data1;
      if (wr_en0 && wr_addr0 == a) return wr_data0;
    end
    return m_mem[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_ready = 1'b0;
      m_sweep = 0;
      m_conf  = 1'b0;
    end else if (!m_ready) begin
      m_mem[m_sweep] = 32'h0;
      m_sweep++;
      m_conf = 1'b0;
      if (m_sweep == DEPTH) begin
        m_ready = 1'b1;
        m_sweep = 0;
      end
    end else if (clr) begin
      m_ready = 1'b0;
      m_sweep = 0;
      m_conf  = 1'b0;
    end else begin
      m_conf = wr_en0 && wr_en1 && wr_addr0 == wr_addr1 && wr_addr0 != 0;
      if (wr_en0 && wr_addr0 != 0) m_mem[wr_addr0] = wr_data0;
      if (wr_en1 && wr_addr1 != 0) m_mem[wr_addr1] = wr_data1;
    end
  endtask

  // Values seen at the last sampling point, for directed checks.
  bit          cap_ready, cap_conf;
  logic [31:0] cap_b [N_RD];
  logic [31:0] cap_n [N_RD];

  // Sample and check on the falling edge, then advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    cap_ready = ready_b;
    cap_conf  = conf_b;
    check("ready_b", 32'(ready_b), 32'(m_ready));
    check("ready_n", 32'(ready_n), 32'(m_ready));
    check("conf_b", 32'(conf_b), 32'(m_conf));
    check("conf_n", 32'(conf_n), 32'(m_conf));
    for (int k = 0; k < N_RD; k++) begin
      cap_b[k] = rd_data_b[k*BW_DATA +: BW_DATA];
      cap_n[k] = rd_data_n[k*BW_DATA +: BW_DATA];
      check($sformatf("rd_b[%0d]", k), cap_b[k], exp_rd(1'b1, rd_addr[k*BW_ADDR +: BW_ADDR]));
      check($sformatf("rd_n[%0d]", k), cap_n[k], exp_rd(1'b0, rd_addr[k*BW_ADDR +: BW_ADDR]));
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    wr_en0 = 1'b0; wr_addr0 = '0; wr_data0 = '0;
    wr_en1 = 1'b0; wr_addr1 = '0; wr_data1 = '0;
    clr    = 1'b0;
  endtask

  task automatic wr(input logic e0, input logic [4:0] a0, input logic [31:0] d0,
                    input logic e1, input logic [4:0] a1, input logic [31:0] d1);
    wr_en0 = e0; wr_addr0 = a0; wr_data0 = d0;
    wr_en1 = e1; wr_addr1 = a1; wr_data1 = d1;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Counts not-ready cycles after the sweep-starting edge; writes are attempted
  // at cycle wr_at (negative disables) to confirm they are ignored.
  task automatic wait_ready(input string tag, input int wr_at);
    int cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (cnt == wr_at) wr(1'b1, 5'd5, 32'h5A5A5A5A, 1'b1, 5'd9, 32'hA5A5A5A5);
      else idle();
      step();
      if (cap_ready) break;
      cnt++;
    end
    idle();
    check(tag, 32'(cnt), 32'd32);
  endtask

  task automatic check_all_zero(input string tag);
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(5'(a), 5'(DEPTH - 1 - a));
      step();
      check(tag, cap_n[0], 32'h0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < DEPTH; a++) m_mem[a] = 32'h0;
    rst = 1'b1;
    idle();
    set_rd(5'd0, 5'd0);
    @(posedge clk);
    model_edge();
    #1;
    step();  // reset still high: reset state checked
    check("reset_ready", 32'(cap_ready), 32'd0);
    check("reset_conf", 32'(cap_conf), 32'd0);
    rst = 1'b0;

    // Sweep after reset release, then every entry reads zero
    wait_ready("rst_sweep_len", -1);
    check_all_zero("post_reset_zero");

    // Write then read; same-cycle bypass vs. no bypass
    wr(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    set_rd(5'd3, 5'd3);
    step();
    check("byp_same_cycle", cap_b[0], 32'hDEADBEEF);
    check("nobyp_same_cycle", cap_n[0], 32'h0);
    idle();
    step();
    check("rd_after_wr_b", cap_b[0], 32'hDEADBEEF);
    check("rd_after_wr_n", cap_n[1], 32'hDEADBEEF);

    // Same-address dual write: port 1 wins, one-cycle conflict pulse
    wr(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22);
    set_rd(5'd7, 5'd3);
    step();
    check("conflict_byp", cap_b[0], 32'h22);
    idle();
    step();
    check("conflict_pulse", 32'(cap_conf), 32'd1);
    check("conflict_value", cap_n[0], 32'h22);
    step();
    check("conflict_drop", 32'(cap_conf), 32'd0);

    // Different-address dual write: both stored, no conflict
    wr(1'b1, 5'd4, 32'hA, 1'b1, 5'd5, 32'hB);
    step();
    idle();
    set_rd(5'd4, 5'd5);
    step();
    check("dual_no_conf", 32'(cap_conf), 32'd0);
    check("dual_addr4", cap_n[0], 32'hA);
    check("dual_addr5", cap_n[1], 32'hB);

    // Zero register: writes dropped, bypass also reads zero, no conflict
    wr(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF);
    set_rd(5'd0, 5'd0);
    step();
    check("zero_byp", cap_b[0], 32'h0);
    idle();
    step();
    check("zero_no_conf", 32'(cap_conf), 32'd0);
    check("zero_read", cap_b[1], 32'h0);

    // Fill, clear, attempt writes during the sweep
    for (int a = 1; a < DEPTH; a++) begin
      wr(1'b1, 5'(a), $urandom, 1'b0, 5'd0, 32'h0);
      set_rd(5'(a), 5'($urandom_range(0, 31)));
      step();
    end
    idle();
    set_rd(5'd5, 5'd9);
    step();
    check("filled_5", cap_n[0], m_mem[5]);
    clr = 1'b1;
    step();
    wait_ready("clr_sweep_len", 3);
    check_all_zero("post_clr_zero");

    // Reset ten cycles into a sweep restarts it
    clr = 1'b1;
    step();
    idle();
    for (int i = 0; i < 10; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_ready("rst_mid_sweep_len", -1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      idle();
      if ($urandom_range(0, 149) == 0) begin
        clr = 1'b1;
      end else begin
        wr($urandom_range(0, 1) == 1,
           ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
           $urandom,
           $urandom_range(0, 1) == 1,
           ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31)),
           $urandom);
      end
      set_rd(5'($urandom_range(0, 31)),
             ($urandom_range(0, 1) == 1) ? wr_addr1 : 5'($urandom_range(0, 31)));
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
